// File: rtl/uart_tx_serializer_if.sv
// Byte-push handshake between the UART MMIO slave and the TX serializer.
//   wr_valid : the slave offers a byte this cycle
//   wr_data  : the byte to transmit
//   wr_ready : the serializer FIFO can take a byte this cycle
// master = the slave that produces bytes, slave = the serializer that consumes them.
interface uart_tx_serializer_if;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: buffers bytes in a FIFO and shifts them out as
// 8N1 frames (start bit, 8 data bits LSB first, stop bit) on the tx line.
// Bit time comes from a programmable divisor (clocks per bit).
// Ports:
//   clock      : system clock, rising edge
//   reset      : asynchronous active-low reset
//   wr_if      : byte push handshake (slave side)
//   div_we     : divisor write strobe
//   div_data   : new divisor in clocks per bit (0 is stored as 1)
//   tx         : serial line, idle high, driven straight from a flop
//   busy       : frame in flight or FIFO non-empty
//   fifo_count : current FIFO occupancy
module uart_tx_serializer #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd16
) (
    input  logic                          clock,
    input  logic                          reset,
    uart_tx_serializer_if.slave           wr_if,
    input  logic                          div_we,
    input  logic [15:0]                   div_data,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(1'b0);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1'b1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [15:0]   baud_q, baud_d;
    logic [15:0]   div_q, div_d;
    logic [15:0]   div_shadow_q, div_shadow_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic          ready_s;
    logic          push_s;
    logic          pop_s;
    logic          bit_end_s;
    logic [7:0]    head_s;

    assign ready_s   = (count_q != FULL_COUNT);
    assign push_s    = wr_if.wr_valid && ready_s;
    assign head_s    = mem_q[rd_ptr_q];
    // The divisor in use is the one latched at frame start, never the live register.
    assign bit_end_s = (baud_q == (div_shadow_q - 16'd1));

    // Frame sequencer: next state, shift/bit/baud counters and the next tx level.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        baud_d       = baud_q;
        div_shadow_d = div_shadow_q;
        tx_d         = tx_q;
        pop_s        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != CNT_ZERO) begin
                    pop_s        = 1'b1;
                    shift_d      = head_s;
                    div_shadow_d = div_q;
                    baud_d       = 16'd0;
                    bit_idx_d    = 3'd0;
                    state_d      = S_START;
                    tx_d         = 1'b0;
                end else begin
                    tx_d = 1'b1;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    baud_d    = 16'd0;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    baud_d = 16'd0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // Present the next bit on the same edge the shift happens.
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end_s) begin
                    baud_d = 16'd0;
                    if (count_q != CNT_ZERO) begin
                        // Back-to-back frame: no idle bit between stop and next start.
                        pop_s        = 1'b1;
                        shift_d      = head_s;
                        div_shadow_d = div_q;
                        bit_idx_d    = 3'd0;
                        state_d      = S_START;
                        tx_d         = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                baud_d  = 16'd0;
            end
        endcase
    end

    // FIFO pointer/occupancy update, divisor register and registered busy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (div_we) begin
            div_d = (div_data == 16'd0) ? 16'd1 : div_data;
        end else begin
            div_d = div_q;
        end
        busy_d = (state_d != S_IDLE) || (count_d != CNT_ZERO);
    end

    // State and control registers; reset aborts any frame and empties the FIFO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            shift_q      <= 8'd0;
            bit_idx_q    <= 3'd0;
            baud_q       <= 16'd0;
            div_q        <= DIV_RESET;
            div_shadow_q <= DIV_RESET;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            wr_ptr_q     <= {AW{1'b0}};
            rd_ptr_q     <= {AW{1'b0}};
            count_q      <= CNT_ZERO;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            baud_q       <= baud_d;
            div_q        <= div_d;
            div_shadow_q <= div_shadow_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_if.wr_data;
        end
    end

    assign wr_if.wr_ready = ready_s;
    assign tx             = tx_q;
    assign busy           = busy_q;
    assign fifo_count     = count_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer. A line-level reference model
// turns every accepted byte into the list of per-cycle tx levels its frame
// must produce, and a compare process checks tx/busy/fifo_count/wr_ready
// against it every cycle; directed literal checks pin the model itself.
module tb_uart_tx_serializer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        div_we = 1'b0;
    logic [15:0] div_data = 16'd0;
    logic        tx;
    logic        busy;
    logic [4:0]  fifo_count;

    uart_tx_serializer_if u_if ();

    uart_tx_serializer #(.FIFO_DEPTH(16), .DIV_RESET(16'd16)) dut (
        .clock      (clock),
        .reset      (reset),
        .wr_if      (u_if),
        .div_we     (div_we),
        .div_data   (div_data),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int stalls   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of pending bytes and queue of future line levels.
    byte unsigned mq[$];
    bit           wave[$];
    int           mdiv = 16;

    initial begin
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                mq.delete();
                wave.delete();
                mdiv = 16;
            end else begin
                bit           do_push;
                byte unsigned b;
                do_push = u_if.wr_valid && (mq.size() != 16);
                if (wave.size() > 0) void'(wave.pop_front());
                if (wave.size() == 0 && mq.size() > 0) begin
                    b = mq.pop_front();
                    for (int i = 0; i < 10; i++) begin
                        bit lvl;
                        if (i == 0)      lvl = 1'b0;
                        else if (i == 9) lvl = 1'b1;
                        else             lvl = b[i-1];
                        for (int j = 0; j < mdiv; j++) wave.push_back(lvl);
                    end
                end
                if (do_push) mq.push_back(u_if.wr_data);
                if (div_we) mdiv = (div_data == 16'd0) ? 1 : int'(div_data);
            end
        end
    end

    // Per-cycle comparison, away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                check("tx_model", tx, (wave.size() > 0) ? 32'(wave[0]) : 32'd1);
                check("busy_model", busy, 32'((wave.size() > 0) || (mq.size() > 0)));
                check("count_model", fifo_count, 32'(mq.size()));
                check("ready_model", u_if.wr_ready, 32'(mq.size() != 16));
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        int guard;
        u_if.wr_valid = 1'b1;
        u_if.wr_data  = b;
        guard = 0;
        while (!u_if.wr_ready && guard < 2000) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 2000) check("push_timeout", guard, 0);
        if (guard > 0) stalls++;
        @(negedge clock);
        u_if.wr_valid = 1'b0;
    endtask

    task automatic set_div(input logic [15:0] v);
        div_we   = 1'b1;
        div_data = v;
        @(negedge clock);
        div_we   = 1'b0;
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while (busy && cyc < 5000) begin
            @(negedge clock);
            cyc++;
        end
        if (cyc >= 5000) check("idle_timeout", cyc, 0);
    endtask

    logic [9:0] a5_line;
    time        t0;
    int         guard;

    initial begin
        u_if.wr_valid = 1'b0;
        u_if.wr_data  = 8'h00;
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", u_if.wr_ready, 1);
        check("rst_count", fifo_count, 0);
        reset = 1'b1;
        @(negedge clock);

        // Single byte 0xA5 at 4 clocks/bit: line 0,1,0,1,0,0,1,0,1,1.
        set_div(16'd4);
        a5_line = 10'b11_0100_1010; // index 0 = start bit
        push_byte(8'hA5);
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 4; j++) begin
                @(negedge clock);
                check("a5_line", tx, 32'(a5_line[i]));
            end
        end
        check("a5_busy_end", busy, 1);
        @(negedge clock);
        check("a5_busy_drop", busy, 0);

        // Fill the FIFO back-to-back at 2 clocks/bit, one extra byte must stall.
        set_div(16'd2);
        stalls = 0;
        for (int k = 0; k < 18; k++) push_byte(8'($urandom_range(0, 255)));
        check("full_stall_seen", 32'(stalls > 0), 1);
        check("full_count_after_refill", fifo_count, 16);
        wait_idle();

        // Divisor write mid-frame: frame 1 at 4/bit, frame 2 at 8/bit.
        set_div(16'd4);
        push_byte(8'h3C);
        t0 = $time;
        push_byte(8'hC3);
        repeat (10) @(negedge clock);
        set_div(16'd8);
        wait_idle();
        check("div_change_span", 32'(($time - t0) / 10), 121);

        // Divisor 0 behaves as 1 clock per bit.
        set_div(16'd0);
        push_byte(8'h96);
        t0 = $time;
        wait_idle();
        check("div_zero_span", 32'(($time - t0) / 10), 11);

        // Reset during data bit 3 with three bytes queued.
        set_div(16'd4);
        push_byte(8'h00);
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        repeat (15) @(negedge clock);
        check("pre_reset_tx_low", tx, 0);
        #2 reset = 1'b0;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_count", fifo_count, 0);
        check("async_rst_busy", busy, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (60) @(negedge clock);
        check("post_reset_tx", tx, 1);
        check("post_reset_busy", busy, 0);

        // Pointer wrap: 40 bytes with low occupancy.
        set_div(16'd1);
        for (int k = 0; k < 40; k++) begin
            guard = 0;
            while (fifo_count >= 5'd3 && guard < 500) begin
                @(negedge clock);
                guard++;
            end
            if (guard >= 500) check("wrap_timeout", guard, 0);
            push_byte(8'($urandom_range(0, 255)));
        end
        wait_idle();

        // Random traffic with occasional divisor writes.
        for (int k = 0; k < 400; k++) begin
            u_if.wr_valid = 1'($urandom_range(0, 1));
            u_if.wr_data  = 8'($urandom_range(0, 255));
            div_we        = ($urandom_range(0, 24) == 0);
            div_data      = 16'($urandom_range(0, 3));
            @(negedge clock);
        end
        u_if.wr_valid = 1'b0;
        div_we        = 1'b0;
        wait_idle();
        repeat (3) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
